prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker.sv | 141 ++++++++++++++
 tb/tb_prbs_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronising Fibonacci-LFSR lock, per-bit error pulses, windowed loss of lock; PRBS_CHK_ERRCNT_EN builds err_count.
// Outputs are registered (one-cycle latency); no backpressure, and din_valid low freezes all state.
module prbs_checker #(
  parameter int N          = 3,
  parameter int TAP_A      = 3,
  parameter int TAP_B      = 2,
  parameter int LOCK_CNT   = 8,
  parameter int WIN_LEN    = 64,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count
);

  localparam int FILL_W = $clog2(N + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WB_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int WE_W   = $clog2(ERR_THRESH + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [WB_W-1:0]   WIN_LAST  = WB_W'(WIN_LEN - 1);
  localparam logic [WE_W-1:0]   ERR_LAST  = WE_W'(ERR_THRESH - 1);

  typedef enum logic [0:0] {HUNT, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      hist_q, hist_d;      // bit 0 is the newest history bit
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [WB_W-1:0]   wb_q, wb_d;
  logic [WE_W-1:0]   we_q, we_d;
  logic              err_d, lost_d;
  logic              exp_bit;

  assign exp_bit = hist_q[TAP_A-1] ^ hist_q[TAP_B-1];

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    good_d  = good_q;
    wb_d    = wb_q;
    we_d    = we_q;
    err_d   = 1'b0;
    lost_d  = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          hist_d = {hist_q[N-2:0], din};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 1'b1;
          end else if (din == exp_bit && |hist_q) begin
            if (good_q == GOOD_LAST) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          // Free-run on the predicted bit so a corrupted input bit is seen only once.
          hist_d = {hist_q[N-2:0], exp_bit};
          err_d  = (din != exp_bit);
          if (err_d && we_q == ERR_LAST) begin
            state_d = HUNT;
            lost_d  = 1'b1;
            fill_d  = '0;
            good_d  = '0;
            wb_d    = '0;
            we_d    = '0;
          end else if (wb_q == WIN_LAST) begin
            wb_d = '0;
            we_d = '0;
          end else begin
            wb_d = wb_q + 1'b1;
            we_d = we_q + WE_W'(err_d);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HUNT;
      hist_q    <= '0;
      fill_q    <= '0;
      good_q    <= '0;
      wb_q      <= '0;
      we_q      <= '0;
      err       <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      good_q    <= good_d;
      wb_q      <= wb_d;
      we_q      <= we_d;
      err       <= err_d;
      lock_lost <= lost_d;
    end
  end

  assign locked = (state_q == LOCKED);

`ifdef PRBS_CHK_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q;

  // A clear coinciding with a counted error leaves that error in the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= CNT_W'(err_d);
    end else if (err_d && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err_count = cnt_q;
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised and directed bench for prbs_checker against a queue-based stream model.
// The model decides lock, error pulses and counts from the recurrence s_k = s_(k-TAP_A) ^ s_(k-TAP_B).
module tb_prbs_checker;

  localparam int N          = 3;
  localparam int TAP_A      = 3;
  localparam int TAP_B      = 2;
  localparam int LOCK_CNT   = 8;
  localparam int WIN_LEN    = 64;
  localparam int ERR_THRESH = 4;
  localparam int CNT_W      = 16;
`ifdef PRBS_CHK_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             din;
  logic             din_valid;
  logic             clear;
  logic             locked;
  logic             err;
  logic             lock_lost;
  logic [CNT_W-1:0] err_count;

  always #5 clk = ~clk;

  prbs_checker #(
    .N(N), .TAP_A(TAP_A), .TAP_B(TAP_B), .LOCK_CNT(LOCK_CNT),
    .WIN_LEN(WIN_LEN), .ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .clear(clear),
    .locked(locked), .err(err), .lock_lost(lock_lost), .err_count(err_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: history as a queue of stream bits (newest at the back).
  bit     hq[$];
  bit     m_locked, m_err, m_ll;
  int     m_fill, m_good, m_wb, m_we;
  longint m_cnt;

  task automatic model_reset();
    hq.delete();
    for (int i = 0; i < N; i++) hq.push_back(1'b0);
    m_locked = 0; m_err = 0; m_ll = 0;
    m_fill = 0; m_good = 0; m_wb = 0; m_we = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit c);
    bit e;
    bit nonzero;
    bit counted;
    m_err = 0; m_ll = 0; counted = 0;
    if (v) begin
      e = hq[hq.size()-TAP_A] ^ hq[hq.size()-TAP_B];
      nonzero = 0;
      foreach (hq[i]) nonzero |= hq[i];
      if (!m_locked) begin
        if (m_fill < N) m_fill++;
        else if (d == e && nonzero) begin
          m_good++;
          if (m_good == LOCK_CNT) begin
            m_locked = 1; m_good = 0; m_wb = 0; m_we = 0;
          end
        end else m_good = 0;
        hq.push_back(d);
      end else begin
        hq.push_back(e);
        if (d != e) begin
          m_err = 1; counted = 1; m_we++;
          if (m_we == ERR_THRESH) begin
            m_locked = 0; m_ll = 1; m_fill = 0; m_good = 0; m_wb = 0; m_we = 0;
          end
        end
        if (m_locked) begin
          if (m_wb == WIN_LEN - 1) begin m_wb = 0; m_we = 0; end
          else m_wb++;
        end
      end
      void'(hq.pop_front());
    end
    if (c) m_cnt = counted ? 1 : 0;
    else if (counted && m_cnt < (64'd1 << CNT_W) - 1) m_cnt++;
  endtask

  function automatic logic [31:0] exp_cnt();
    return CNT_EN ? 32'(m_cnt) : 32'd0;
  endfunction

  logic [6:0] pat;
  int         src_idx;

  function automatic bit src_bit();
    return pat[6 - (src_idx % 7)];
  endfunction

  task automatic drive(input bit v, input bit d, input bit c);
    @(negedge clk);
    din = d; din_valid = v; clear = c;
    model_step(v, d, c);
    @(posedge clk);
    #1;
    check("locked", 32'(locked), 32'(m_locked));
    check("err", 32'(err), 32'(m_err));
    check("lock_lost", 32'(lock_lost), 32'(m_ll));
    check("err_count", 32'(err_count), exp_cnt());
  endtask

  task automatic send(input bit v, input bit flip, input bit c);
    bit d;
    d = v ? (src_bit() ^ flip) : 1'($urandom_range(0, 1));
    drive(v, d, c);
    if (v) src_idx++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 reset_n = 1'b0;
    din_valid = 1'b0; clear = 1'b0;
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_lock_lost", 32'(lock_lost), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    model_reset();
    src_idx = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int nv;
    int lock_at;
    pat = 7'b1001011;
    src_idx = 0;
    reset_n = 1'b0; din = 1'b0; din_valid = 1'b0; clear = 1'b0;
    model_reset();
    #2;
    check("init_locked", 32'(locked), 32'd0);
    check("init_err", 32'(err), 32'd0);
    check("init_lock_lost", 32'(lock_lost), 32'd0);
    check("init_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Clean stream locks on the 11th valid bit.
    nv = 0; lock_at = 0;
    for (int i = 0; i < 40 && lock_at == 0; i++) begin
      send(1, 0, 0); nv++;
      if (locked) lock_at = nv;
    end
    check("lock_at_clean", 32'(lock_at), 32'd11);
    for (int i = 0; i < 20; i++) send(1, 0, 0);

    // Single inverted bit.
    send(1, 1, 0);
    for (int i = 0; i < 10; i++) send(1, 0, 0);
    check("single_cnt", 32'(err_count), CNT_EN ? 32'd1 : 32'd0);
    check("single_locked", 32'(locked), 32'd1);

    // Four errors inside one window drop lock.
    for (int i = 0; i < 70; i++) send(1, 0, i == 0);
    for (int k = 0; k < 4; k++) begin
      send(1, 1, 0);
      send(1, 0, 0); send(1, 0, 0);
    end
    check("four_locked", 32'(locked), 32'd0);
    check("four_cnt", 32'(err_count), CNT_EN ? 32'd4 : 32'd0);

    // Relock, then 3 errors in each of two consecutive windows.
    for (int i = 0; i < 20; i++) send(1, 0, i == 0);
    for (int i = 0; i < 70 && m_wb != 0; i++) send(1, 0, 0);
    for (int i = 0; i < 130; i++)
      send(1, (i == 5 || i == 10 || i == 15 || i == 70 || i == 75 || i == 80), 0);
    check("twowin_locked", 32'(locked), 32'd1);
    check("twowin_cnt", 32'(err_count), CNT_EN ? 32'd6 : 32'd0);

    // Clear coinciding with a counted error.
    send(1, 1, 1);
    check("clear_err_cnt", 32'(err_count), CNT_EN ? 32'd1 : 32'd0);
    send(1, 0, 1);
    check("clear_only_cnt", 32'(err_count), 32'd0);

    // Reset while locked, then relock with din_valid toggling.
    pulse_reset();
    nv = 0; lock_at = 0;
    for (int i = 0; i < 80 && lock_at == 0; i++) begin
      send(i % 2 == 0, 0, 0);
      if (i % 2 == 0) nv++;
      if (locked) lock_at = nv;
    end
    check("lock_at_toggle", 32'(lock_at), 32'd11);

    // All-zero stream never locks.
    pulse_reset();
    for (int i = 0; i < 40; i++) drive(1, 1'b0, 0);
    check("zero_locked", 32'(locked), 32'd0);
    check("zero_cnt", 32'(err_count), 32'd0);

    // Randomised traffic: gaps, sparse errors, occasional clears and resets.
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) pulse_reset();
      send($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
